// File: rtl/fft_bf_sequencer.sv
// rtl/fft_bf_sequencer.sv - radix-2 in-place FFT butterfly sequencer (stage/address/twiddle/write-back timing)
// Optional macro FFT_SEQ_BITREV_EN: bit-reverse stage-0 read addresses so natural-order input can be used.
module fft_bf_sequencer #(
  parameter int N_LOG2   = 4,
  parameter int PIPE_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic [N_LOG2-1:0] stage,
  output logic [N_LOG2-1:0] rd_addr_a,
  output logic [N_LOG2-1:0] rd_addr_b,
  output logic [N_LOG2-2:0] tw_addr,
  output logic              bf_en,
  output logic              bf_en_modify,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_addr_a,
  output logic [N_LOG2-1:0] wr_addr_b,
  output logic              bank_sel
);

  localparam int HALF = 1 << (N_LOG2 - 1);
  localparam logic [N_LOG2-2:0] LAST_IDX   = (N_LOG2-1)'(HALF - 1);
  localparam logic [N_LOG2-1:0] LAST_STAGE = N_LOG2'(N_LOG2 - 1);
  localparam logic [3:0]        LAST_DRAIN = 4'(PIPE_LAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

  state_t            state;
  logic [N_LOG2-2:0] bf_idx;
  logic [3:0]        drain_cnt;
  logic [N_LOG2-1:0] a_r, b_r;
  logic [N_LOG2-2:0] tw_r;
  logic [N_LOG2-2:0] nxt_idx;
  logic [N_LOG2-1:0] nxt_stage;

  logic              en_d [PIPE_LAT];
  logic [N_LOG2-1:0] a_d  [PIPE_LAT];
  logic [N_LOG2-1:0] b_d  [PIPE_LAT];

  function automatic logic [N_LOG2-1:0] addr_a(input logic [N_LOG2-1:0] st, input logic [N_LOG2-2:0] idx);
    int span, grp, pos;
    span = 1 << int'(st);
    grp  = int'(idx) >> int'(st);
    pos  = int'(idx) & (span - 1);
    return N_LOG2'(grp * 2 * span + pos);
  endfunction

  function automatic logic [N_LOG2-1:0] addr_b(input logic [N_LOG2-1:0] st, input logic [N_LOG2-2:0] idx);
    return addr_a(st, idx) + N_LOG2'(1 << int'(st));
  endfunction

  function automatic logic [N_LOG2-2:0] tw_of(input logic [N_LOG2-1:0] st, input logic [N_LOG2-2:0] idx);
    int pos;
    pos = int'(idx) & ((1 << int'(st)) - 1);
    return (N_LOG2-1)'(pos << (N_LOG2 - 1 - int'(st)));
  endfunction

  assign nxt_idx   = bf_idx + 1'b1;
  assign nxt_stage = stage + 1'b1;

  // Address registers always hold the butterfly presented this cycle, so DRAIN keeps them stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      stage     <= '0;
      bf_idx    <= '0;
      drain_cnt <= '0;
      a_r       <= '0;
      b_r       <= '0;
      tw_r      <= '0;
      bank_sel  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state    <= RUN;
          stage    <= '0;
          bf_idx   <= '0;
          bank_sel <= 1'b0;
          a_r      <= addr_a('0, '0);
          b_r      <= addr_b('0, '0);
          tw_r     <= tw_of('0, '0);
        end
        RUN: if (!hold) begin
          if (bf_idx == LAST_IDX) begin
            state     <= DRAIN;
            drain_cnt <= '0;
            bf_idx    <= '0;
          end else begin
            bf_idx <= nxt_idx;
            a_r    <= addr_a(stage, nxt_idx);
            b_r    <= addr_b(stage, nxt_idx);
            tw_r   <= tw_of(stage, nxt_idx);
          end
        end
        DRAIN: if (!hold) begin
          if (drain_cnt == LAST_DRAIN) begin
            if (stage == LAST_STAGE) begin
              state <= FINISH;
            end else begin
              state    <= RUN;
              stage    <= nxt_stage;
              bank_sel <= ~bank_sel;
              a_r      <= addr_a(nxt_stage, '0);
              b_r      <= addr_b(nxt_stage, '0);
              tw_r     <= tw_of(nxt_stage, '0);
            end
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < PIPE_LAT; k++) begin
        en_d[k] <= 1'b0;
        a_d[k]  <= '0;
        b_d[k]  <= '0;
      end
    end else if (!hold) begin
      en_d[0] <= (state == RUN);
      a_d[0]  <= a_r;
      b_d[0]  <= b_r;
      for (int k = 1; k < PIPE_LAT; k++) begin
        en_d[k] <= en_d[k-1];
        a_d[k]  <= a_d[k-1];
        b_d[k]  <= b_d[k-1];
      end
    end
  end

  assign busy         = (state == RUN) || (state == DRAIN);
  assign done         = (state == FINISH);
  assign bf_en        = (state == RUN) && !hold;
  assign bf_en_modify = bf_en && (tw_r == '0);
  assign tw_addr      = tw_r;
  assign wr_en        = en_d[PIPE_LAT-1] && !hold;
  assign wr_addr_a    = a_d[PIPE_LAT-1];
  assign wr_addr_b    = b_d[PIPE_LAT-1];

`ifdef FFT_SEQ_BITREV_EN
  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++) r[i] = v[N_LOG2-1-i];
    return r;
  endfunction

  assign rd_addr_a = (stage == '0) ? bitrev(a_r) : a_r;
  assign rd_addr_b = (stage == '0) ? bitrev(b_r) : b_r;
`else
  assign rd_addr_a = a_r;
  assign rd_addr_b = b_r;
`endif

endmodule

// File: doc/fft_bf_sequencer.md
Name: fft_bf_sequencer

Overview:
- Controller that sequences the radix-2 butterfly adder of the in-place FFT engine across all log2(N) stages.
- Per butterfly it generates the operand read addresses, the twiddle ROM address, the adder enables (`bf_en`, `bf_en_modify`) and the delayed write-back addresses for the result.
- Sits between the top-level FFT start/done handshake and the ping-pong data RAM, twiddle ROM and adder datapath.

Parameters:
- N_LOG2, 4, log2 of FFT length N (N = 16 default).
- PIPE_LAT, 3, cycles from read-address issue to adder result valid at the RAM write port; legal range 1..8.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to run a full transform.
- hold  in  1  global stall; freezes the sequencer and the write-back delay line.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse at end of transform.
- stage  out  N_LOG2  current stage index, 0..N_LOG2-1.
- rd_addr_a  out  N_LOG2  top-operand read address.
- rd_addr_b  out  N_LOG2  bottom-operand read address.
- tw_addr  out  N_LOG2-1  twiddle ROM address.
- bf_en  out  1  adder enable; one butterfly issued this cycle.
- bf_en_modify  out  1  selects the trivial-twiddle adder path; asserted when tw_addr == 0.
- wr_en  out  1  write-back strobe, equal to bf_en delayed by PIPE_LAT.
- wr_addr_a  out  N_LOG2  rd_addr_a delayed by PIPE_LAT.
- wr_addr_b  out  N_LOG2  rd_addr_b delayed by PIPE_LAT.
- bank_sel  out  1  ping-pong RAM read bank; write bank = ~bank_sel.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, counters and delay line cleared. Reset mid-transform aborts immediately; no done pulse.
- FSM states: IDLE, RUN, DRAIN, FINISH.
- IDLE -> RUN on start. Counters cleared (stage = 0, bf_idx = 0), bank_sel = 0. start is ignored in every other state.
- RUN issues one butterfly per cycle while hold = 0:
  - bf_en = 1.
  - span = 1 << stage; grp = bf_idx >> stage; pos = bf_idx & (span - 1).
  - rd_addr_a = grp*2*span + pos; rd_addr_b = rd_addr_a + span.
  - tw_addr = pos << (N_LOG2-1-stage); bf_en_modify = (tw_addr == 0).
  - bf_idx increments and wraps 0..N/2-1.
  - After issuing bf_idx = N/2-1 -> DRAIN.
- DRAIN:
  - bf_en = 0; rd/tw address outputs hold their last values; bf_en_modify = 0.
  - Lasts exactly PIPE_LAT un-held cycles so the last write of a stage lands before the next stage reads.
  - On exit: if stage == N_LOG2-1 -> FINISH; else stage+1, bank_sel toggles, bf_idx = 0 -> RUN.
- FINISH: done = 1 for one cycle, busy drops in that same cycle, then -> IDLE.
- Delay line: shift register of depth PIPE_LAT carrying {bf_en, rd_addr_a, rd_addr_b}; its outputs drive wr_en, wr_addr_a, wr_addr_b.
- hold = 1 freezes the FSM, counters and delay line:
  - bf_en = 0 and wr_en = 0 while held.
  - Address outputs keep their values.
  - Hold in IDLE does not block acceptance of start.
- Transform length: N_LOG2*(N/2 + PIPE_LAT) un-held cycles from the first RUN cycle to the last DRAIN cycle.

Optional Feature:
- Macro FFT_SEQ_BITREV_EN.
- Defined: in stage 0 only, rd_addr_a and rd_addr_b are output bit-reversed over N_LOG2 bits, which lets natural-order input feed DIT stages. Write addresses stay natural, taken from the pre-reversal values.
- Undefined: no reversal; input must already be bit-reversed in RAM.

Test Plan (N_LOG2 = 3, PIPE_LAT = 2, macro undefined unless stated):
- Pulse start at cycle 0 -> busy = 1 from cycle 1; bf_en = 1 in cycles 1-4, 7-10, 13-16; done = 1 at cycle 19 only; busy = 0 at cycle 19.
- Stage 1 issues -> rd_addr_a = 0,1,4,5; rd_addr_b = 2,3,6,7; tw_addr = 0,2,0,2; bf_en_modify = 1,0,1,0.
- Stage 0 -> wr_en = 1 in cycles 3-6 with wr_addr_a = 0,2,4,6 and wr_addr_b = 1,3,5,7; bank_sel toggles 0 -> 1 at cycle 7.
- hold = 1 for cycles 2-3 -> stage 0 issues in cycles 1, 4, 5, 6; no address skipped or repeated; done delayed to cycle 21.
- rst asserted at cycle 9 -> all outputs 0 immediately; start at cycle 12 runs a full transform, done at cycle 31. A start pulse during busy has no effect.
- FFT_SEQ_BITREV_EN defined, stage 0 -> rd_addr_a = 0,2,1,3; rd_addr_b = 4,6,5,7; wr_addr_a = 0,2,4,6 (unreversed).
